// File: rtl/register_file.sv
// Parametrised general-purpose register file: two combinational read ports,
// one enabled write port, optional hardwired-zero register 0, optional
// write-to-read bypass, and a clear engine that zeroes one register per cycle.
//
// Handshake/timing contract: write_enable is a single-cycle command sampled
// at each rising edge, with no back-pressure. An enabled write that arrives
// while busy is high is dropped, and write_dropped pulses for the cycle after
// that edge. clear is a level sampled in IDLE only. busy stays high for
// exactly NUM_REGS cycles. done pulses for the one cycle after the last
// register has been zeroed.
module register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_REGS   = 16,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   read1_id,
  output logic [DATA_WIDTH-1:0] read1_value,
  input  logic [ID_WIDTH-1:0]   read2_id,
  output logic [DATA_WIDTH-1:0] read2_value,
  input  logic                  write_enable,
  input  logic [ID_WIDTH-1:0]   write_id,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  write_dropped
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Last id the sweep touches. The pointer is reset rather than incremented
  // past this value, so it never wraps when NUM_REGS == 2**ID_WIDTH.
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REGS - 1);
  // One extra bit so that NUM_REGS == 2**ID_WIDTH is representable.
  localparam logic [ID_WIDTH:0]   REG_COUNT = (ID_WIDTH + 1)'(NUM_REGS);

  state_t                  state;
  logic [ID_WIDTH-1:0]     pointer;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic                    write_valid;
  logic                    write_commit;

  // Decide whether the write port updates a register at the coming edge.
  always_comb begin
    write_valid  = ({1'b0, write_id} < REG_COUNT) &&
                   !((ZERO_REG != 0) && (write_id == '0));
    write_commit = write_enable && !busy && write_valid;
  end

  // Combinational read ports with range, zero-register and bypass handling.
  always_comb begin
    read1_value = '0;
    read2_value = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (read1_id == ID_WIDTH'(k)) read1_value = regs[k];
      if (read2_id == ID_WIDTH'(k)) read2_value = regs[k];
    end
    if ((ZERO_REG != 0) && (read1_id == '0)) read1_value = '0;
    if ((ZERO_REG != 0) && (read2_id == '0)) read2_value = '0;
    // write_commit already excludes out-of-range ids and the zero register.
    if ((BYPASS != 0) && write_commit && (read1_id == write_id)) read1_value = write_value;
    if ((BYPASS != 0) && write_commit && (read2_id == write_id)) read2_value = write_value;
  end

  // Register storage, clear-sweep FSM and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      state         <= IDLE;
      pointer       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      done          <= 1'b0;
      write_dropped <= write_enable && busy;

      // Writes only commit in IDLE, so they never collide with the sweep.
      for (int k = 0; k < NUM_REGS; k++) begin
        if (write_commit && (write_id == ID_WIDTH'(k))) regs[k] <= write_value;
      end

      case (state)
        IDLE: begin
          if (clear) begin
            state   <= SWEEP;
            busy    <= 1'b1;
            pointer <= '0;
          end
        end
        SWEEP: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (pointer == ID_WIDTH'(k)) regs[k] <= '0;
          end
          if (pointer == LAST_ID) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pointer <= '0;
          end else begin
            pointer <= pointer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file. Instance a uses the default
// parameters (16 registers, no zero register, no bypass). Instance b uses
// 12 registers with a hardwired-zero register 0 and the bypass enabled.
module tb_register_file;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance a: defaults.
  logic [3:0] a_read1_id, a_read2_id, a_write_id;
  logic [7:0] a_read1_value, a_read2_value, a_write_value;
  logic       a_write_enable, a_clear, a_busy, a_done, a_write_dropped;

  // Instance b: NUM_REGS = 12, ZERO_REG = 1, BYPASS = 1.
  logic [3:0] b_read1_id, b_read2_id, b_write_id;
  logic [7:0] b_read1_value, b_read2_value, b_write_value;
  logic       b_write_enable, b_clear, b_busy, b_done, b_write_dropped;

  register_file #(
    .DATA_WIDTH(8), .ID_WIDTH(4), .NUM_REGS(16), .ZERO_REG(0), .BYPASS(0)
  ) dut_a (
    .clock(clock), .reset(reset),
    .read1_id(a_read1_id), .read1_value(a_read1_value),
    .read2_id(a_read2_id), .read2_value(a_read2_value),
    .write_enable(a_write_enable), .write_id(a_write_id), .write_value(a_write_value),
    .clear(a_clear), .busy(a_busy), .done(a_done), .write_dropped(a_write_dropped)
  );

  register_file #(
    .DATA_WIDTH(8), .ID_WIDTH(4), .NUM_REGS(12), .ZERO_REG(1), .BYPASS(1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .read1_id(b_read1_id), .read1_value(b_read1_value),
    .read2_id(b_read2_id), .read2_value(b_read2_value),
    .write_enable(b_write_enable), .write_id(b_write_id), .write_value(b_write_value),
    .clear(b_clear), .busy(b_busy), .done(b_done), .write_dropped(b_write_dropped)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_a(input logic [3:0] id1, input logic [3:0] id2);
    a_read1_id = id1;
    a_read2_id = id2;
    #1;
  endtask

  task automatic fill_a();
    a_write_enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a_write_id    = 4'(k);
      a_write_value = 8'h10 + 8'(k);
      tick();
    end
    a_write_enable = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int busy_cycles;
  int guard;

  initial begin
    reset = 1'b1;
    a_read1_id = '0; a_read2_id = '0; a_write_id = '0; a_write_value = '0;
    a_write_enable = 1'b0; a_clear = 1'b0;
    b_read1_id = '0; b_read2_id = '0; b_write_id = '0; b_write_value = '0;
    b_write_enable = 1'b0; b_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    read_a(4'd3, 4'd4);
    check("rst_a_r1_id3", a_read1_value, 8'h00);
    check("rst_a_r2_id4", a_read2_value, 8'h00);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_done", a_done, 1'b0);
    check("rst_a_dropped", a_write_dropped, 1'b0);
    b_read1_id = 4'd14;
    #1;
    check("rst_b_r1_id14", b_read1_value, 8'h00);

    // Write reg 2, then a disabled write must not change it.
    a_write_enable = 1'b1; a_write_id = 4'd2; a_write_value = 8'h55;
    tick();
    a_write_enable = 1'b0; a_write_value = 8'hFF;
    tick();
    read_a(4'd2, 4'd3);
    check("wr_a_reg2", a_read1_value, 8'h55);
    check("wr_a_reg3", a_read2_value, 8'h00);

    // Bypass vs. no bypass on reg 5.
    a_write_enable = 1'b1; a_write_id = 4'd5; a_write_value = 8'hA3; a_read1_id = 4'd5;
    b_write_enable = 1'b1; b_write_id = 4'd5; b_write_value = 8'hA3; b_read1_id = 4'd5;
    #1;
    check("nobyp_a_before", a_read1_value, 8'h00);
    check("byp_b_before", b_read1_value, 8'hA3);
    tick();
    a_write_enable = 1'b0;
    b_write_enable = 1'b0;
    #1;
    check("nobyp_a_after", a_read1_value, 8'hA3);
    check("byp_b_after", b_read1_value, 8'hA3);

    // Zero register on b: the write is discarded and bypass must not apply.
    b_write_enable = 1'b1; b_write_id = 4'd0; b_write_value = 8'h7E;
    b_read1_id = 4'd0; b_read2_id = 4'd0;
    #1;
    check("zero_b_byp_r1", b_read1_value, 8'h00);
    tick();
    b_write_enable = 1'b0;
    #1;
    check("zero_b_r1", b_read1_value, 8'h00);
    check("zero_b_r2", b_read2_value, 8'h00);

    // Out-of-range write on b (id 13 >= 12) is discarded, with no bypass.
    b_write_enable = 1'b1; b_write_id = 4'd13; b_write_value = 8'h99; b_read1_id = 4'd13;
    #1;
    check("oor_b_byp", b_read1_value, 8'h00);
    tick();
    b_write_enable = 1'b0;
    #1;
    check("oor_b_read", b_read1_value, 8'h00);

    // Top register of a full-size file.
    a_write_enable = 1'b1; a_write_id = 4'd15; a_write_value = 8'hE1;
    tick();
    a_write_enable = 1'b0;
    read_a(4'd15, 4'd14);
    check("wr_a_reg15", a_read1_value, 8'hE1);

    // Fill and sweep. Clear is sampled at edge N.
    fill_a();
    read_a(4'd0, 4'd15);
    check("fill_a_reg0", a_read1_value, 8'h10);
    check("fill_a_reg15", a_read2_value, 8'h1F);
    a_clear = 1'b1;
    tick();                                   // edge N
    a_clear = 1'b0;
    busy_cycles = 0;
    if (a_busy) busy_cycles++;
    check("sweep_busy_start", a_busy, 1'b1);
    check("sweep_done_start", a_done, 1'b0);

    // A write during the sweep is dropped.
    a_write_enable = 1'b1; a_write_id = 4'd9; a_write_value = 8'hCC;
    tick();                                   // edge N+1
    a_write_enable = 1'b0;
    if (a_busy) busy_cycles++;
    check("drop_pulse", a_write_dropped, 1'b1);
    tick();                                   // edge N+2
    if (a_busy) busy_cycles++;
    check("drop_pulse_end", a_write_dropped, 1'b0);
    for (int i = 3; i <= 8; i++) begin
      tick();
      if (a_busy) busy_cycles++;
    end
    // After 8 sweep edges, regs 0..7 are zero.
    read_a(4'd7, 4'd8);
    check("mid_sweep_reg7", a_read1_value, 8'h00);
    check("mid_sweep_reg8", a_read2_value, 8'h18);
    read_a(4'd9, 4'd15);
    check("mid_sweep_reg9", a_read1_value, 8'h19);
    check("mid_sweep_reg15", a_read2_value, 8'h1F);

    // A clear while busy must not restart the sweep.
    a_clear = 1'b1;
    tick();                                   // edge N+9
    a_clear = 1'b0;
    if (a_busy) busy_cycles++;
    guard = 0;
    while (a_busy && guard < 40) begin
      tick();
      guard++;
      if (a_busy) busy_cycles++;
    end
    check("sweep_timeout", 8'(guard < 40), 8'd1);
    check("sweep_busy_cycles", 8'(busy_cycles), 8'd16);
    check("sweep_done_pulse", a_done, 1'b1);
    tick();
    check("sweep_done_once", a_done, 1'b0);
    check("sweep_busy_after", a_busy, 1'b0);
    for (int k = 0; k < 16; k += 2) begin
      read_a(4'(k), 4'(k + 1));
      check($sformatf("swept_reg%0d", k), a_read1_value, 8'h00);
      check($sformatf("swept_reg%0d", k + 1), a_read2_value, 8'h00);
    end

    // Reset during the sweep aborts it, with no done pulse.
    fill_a();
    a_clear = 1'b1;
    tick();                                   // edge N
    a_clear = 1'b0;
    for (int i = 1; i <= 5; i++) tick();      // sweep cycle 5
    check("abort_busy_before", a_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", a_busy, 1'b0);
    check("abort_done", a_done, 1'b0);
    tick();
    check("abort_done_next", a_done, 1'b0);
    check("abort_busy_next", a_busy, 1'b0);
    for (int k = 0; k < 16; k += 2) begin
      read_a(4'(k), 4'(k + 1));
      check($sformatf("abort_reg%0d", k), a_read1_value, 8'h00);
      check($sformatf("abort_reg%0d", k + 1), a_read2_value, 8'h00);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
